// File: rtl/acc_fifo_pkg.sv
// Shared defaults and read-mode encoding for the accumulating FIFO slice.
package acc_fifo_pkg;

    localparam int ACC_DATA_W = 32;
    localparam int ACC_DEPTH  = 16;

    typedef enum logic {
        FWFT_REGISTERED  = 1'b0,
        FWFT_FALLTHROUGH = 1'b1
    } fwft_mode_e;

endpackage : acc_fifo_pkg

// File: rtl/acc_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module acc_fifo_mem #(
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : acc_fifo_mem

// File: rtl/acc_fifo.sv
// Synchronous FIFO with runtime full threshold, flush, enable gating and
// sticky overflow/underflow flags; registered or fall-through read.
module acc_fifo
    import acc_fifo_pkg::*;
#(
    parameter int  DATA_W = ACC_DATA_W,
    parameter int  DEPTH  = ACC_DEPTH,
    parameter int  FWFT   = 0,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              flush,
    input  logic [CW-1:0]     level_cfg,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clear_err
);

    localparam int              AW      = $clog2(DEPTH);
    localparam fwft_mode_e      MODE    = (FWFT != 0) ? FWFT_FALLTHROUGH : FWFT_REGISTERED;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     lim;
    logic              push_acc;
    logic              pop_acc;
    logic              ovf_set;
    logic              unf_set;
    logic [DATA_W-1:0] mem_rdata;

    // Zero or out-of-range thresholds fall back to the physical depth.
    always_comb begin
        lim = level_cfg;
        if ((level_cfg == '0) || (level_cfg > DEPTH_C)) begin
            lim = DEPTH_C;
        end
    end

    always_comb begin
        full        = (count >= lim);
        empty       = (count == '0);
        almost_full = (count >= (lim - CW'(1)));
        push_acc    = enable & push & ~full  & ~flush;
        pop_acc     = enable & pop  & ~empty & ~flush;
        ovf_set     = enable & push & full  & ~flush;
        unf_set     = enable & pop  & empty & ~flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (enable) begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_acc) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop_acc) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push_acc != pop_acc) begin
                    count <= push_acc ? (count + CW'(1)) : (count - CW'(1));
                end
            end
        end
    end

    // Error flags ignore enable so clear_err always works; a new set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
            end
            if (unf_set) begin
                underflow <= 1'b1;
            end else if (clear_err) begin
                underflow <= 1'b0;
            end
        end
    end

    acc_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_acc),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    generate
        if (MODE == FWFT_FALLTHROUGH) begin : g_fwft
            assign dout       = mem_rdata;
            assign dout_valid = ~empty;
        end else begin : g_reg
            logic [DATA_W-1:0] dout_q;
            logic              dout_valid_q;

            // Flush drops pop_acc, which also clears the valid pulse.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q       <= '0;
                    dout_valid_q <= 1'b0;
                end else if (enable) begin
                    dout_valid_q <= pop_acc;
                    if (pop_acc) begin
                        dout_q <= mem_rdata;
                    end
                end
            end

            assign dout       = dout_q;
            assign dout_valid = dout_valid_q;
        end
    endgenerate

endmodule : acc_fifo

// File: tb/tb_acc_fifo.sv
// Self-checking bench for acc_fifo (DEPTH=16, registered read) against a queue model.
module tb_acc_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              flush;
    logic [CW-1:0]     level_cfg;
    logic              push;
    logic [DATA_W-1:0] din;
    logic              pop;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;
    logic              clear_err;

    int n_pass = 0;
    int n_total = 0;

    acc_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .FWFT   (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .flush       (flush),
        .level_cfg   (level_cfg),
        .push        (push),
        .din         (din),
        .pop         (pop),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .clear_err   (clear_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff_lim(input logic [CW-1:0] cfg);
        if (cfg == 0 || int'(cfg) > DEPTH) return DEPTH;
        return int'(cfg);
    endfunction

    // Behavioural model: a plain queue plus the observable registers.
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_dout;
    bit                m_dv, m_ov, m_un;
    int                s_lim;
    bit                s_full, s_empty, s_pa, s_qa;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_dout = '0;
            m_dv   = 0;
            m_ov   = 0;
            m_un   = 0;
        end else begin
            s_lim   = eff_lim(level_cfg);
            s_full  = q.size() >= s_lim;
            s_empty = q.size() == 0;
            s_pa    = enable && push && !s_full && !flush;
            s_qa    = enable && pop && !s_empty && !flush;
            if (enable && push && s_full && !flush) m_ov = 1;
            else if (clear_err) m_ov = 0;
            if (enable && pop && s_empty && !flush) m_un = 1;
            else if (clear_err) m_un = 0;
            if (enable) begin
                if (flush) begin
                    q.delete();
                    m_dv = 0;
                end else begin
                    m_dv = s_qa;
                    if (s_qa) m_dout = q.pop_front();
                    if (s_pa) q.push_back(din);
                end
            end
        end
    end

    int c_lim;
    always @(negedge clk) begin
        c_lim = eff_lim(level_cfg);
        check("count",       64'(count),       64'(q.size()));
        check("empty",       64'(empty),       64'(q.size() == 0));
        check("full",        64'(full),        64'(q.size() >= c_lim));
        check("almost_full", 64'(almost_full), 64'(q.size() >= c_lim - 1));
        check("overflow",    64'(overflow),    64'(m_ov));
        check("underflow",   64'(underflow),   64'(m_un));
        check("dout_valid",  64'(dout_valid),  64'(m_dv));
        check("dout",        64'(dout),        64'(m_dout));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        enable    = 1'b1;
        flush     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        clear_err = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        level_cfg = '0;
        din       = '0;
        idle();
        repeat (3) tick();
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full",  64'(full),  64'd0);
        check("rst_af",    64'(almost_full), 64'd0);
        rst_n = 1'b1;
        tick();

        // Fill and drain
        for (int i = 0; i < 16; i++) begin
            push = 1'b1;
            din  = 32'(i);
            tick();
            if (i == 14) begin
                check("fill_af15",   64'(almost_full), 64'd1);
                check("fill_full15", 64'(full),        64'd0);
            end
        end
        push = 1'b0;
        check("fill_count", 64'(count), 64'd16);
        check("fill_full",  64'(full),  64'd1);
        pop = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("drain_dout", 64'(dout),       64'(i));
            check("drain_dv",   64'(dout_valid), 64'd1);
        end
        pop = 1'b0;
        check("drain_empty", 64'(empty), 64'd1);
        tick();
        check("drain_dv_low", 64'(dout_valid), 64'd0);

        // Threshold
        level_cfg = CW'(4);
        for (int i = 1; i <= 5; i++) begin
            push = 1'b1;
            din  = 32'(i);
            tick();
            if (i == 2) check("thr_af2", 64'(almost_full), 64'd0);
            if (i == 3) begin
                check("thr_af3",   64'(almost_full), 64'd1);
                check("thr_full3", 64'(full),        64'd0);
            end
            if (i == 4) check("thr_full4", 64'(full), 64'd1);
        end
        push = 1'b0;
        check("thr_count", 64'(count),    64'd4);
        check("thr_ovf",   64'(overflow), 64'd1);
        flush     = 1'b1;
        clear_err = 1'b1;
        tick();
        idle();
        level_cfg = '0;
        check("thr_ovf_clr", 64'(overflow), 64'd0);

        // Simultaneous push/pop across pointer wrap
        for (int i = 0; i < 8; i++) begin
            push = 1'b1;
            din  = 32'(100 + i);
            tick();
        end
        pop = 1'b1;
        for (int k = 0; k < 20; k++) begin
            din = 32'(200 + k);
            tick();
            check("sim_count", 64'(count), 64'd8);
            check("sim_dout",  64'(dout),  (k < 8) ? 64'(100 + k) : 64'(192 + k));
        end
        idle();

        // Flush priority and enable hold
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push = 1'b1;
            din  = 32'(300 + i);
            tick();
        end
        check("fl_count6", 64'(count), 64'd6);
        flush = 1'b1;
        push  = 1'b1;
        pop   = 1'b1;
        din   = 32'd999;
        tick();
        idle();
        check("fl_count", 64'(count),      64'd0);
        check("fl_dv",    64'(dout_valid), 64'd0);
        check("fl_dout",  64'(dout),       64'd211);
        enable = 1'b0;
        push   = 1'b1;
        din    = 32'd777;
        tick();
        idle();
        check("en_count", 64'(count), 64'd0);
        check("en_empty", 64'(empty), 64'd1);

        // Error flags
        pop = 1'b1;
        tick();
        check("err_unf", 64'(underflow), 64'd1);
        clear_err = 1'b1;
        tick();
        check("err_unf_hold", 64'(underflow), 64'd1);
        pop = 1'b0;
        tick();
        clear_err = 1'b0;
        check("err_unf_clr", 64'(underflow), 64'd0);

        // Reset mid-burst
        for (int i = 0; i < 5; i++) begin
            push = 1'b1;
            din  = 32'(400 + i);
            tick();
        end
        check("rb_count5", 64'(count), 64'd5);
        din = 32'd405;
        #1;
        rst_n = 1'b0;
        #1;
        check("rb_count", 64'(count),       64'd0);
        check("rb_empty", 64'(empty),       64'd1);
        check("rb_full",  64'(full),        64'd0);
        check("rb_af",    64'(almost_full), 64'd0);
        check("rb_dout",  64'(dout),        64'd0);
        check("rb_dv",    64'(dout_valid),  64'd0);
        push = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        push = 1'b1;
        din  = 32'hABCD_1234;
        tick();
        push = 1'b0;
        pop  = 1'b1;
        tick();
        pop = 1'b0;
        check("rb_readback", 64'(dout),       64'hABCD_1234);
        check("rb_rb_dv",    64'(dout_valid), 64'd1);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) level_cfg = CW'($urandom_range(0, 31));
            enable    = ($urandom_range(0, 99) < 90);
            flush     = ($urandom_range(0, 99) < 3);
            clear_err = ($urandom_range(0, 99) < 5);
            push      = ($urandom_range(0, 99) < 55);
            pop       = ($urandom_range(0, 99) < 45);
            din       = $urandom;
            tick();
        end
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_acc_fifo

// File: doc/acc_fifo.md
ACC_FIFO -- requirements
Module: acc_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning storage entries; legal values are powers of two, 2 to 256.
REQ-003 SHALL have parameter FWFT, default 0, meaning 0 = registered read and 1 = first-word-fall-through.
REQ-004 SHALL derive local parameter CW = $clog2(DEPTH)+1 for count and threshold widths.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port enable, input, 1 bit: when low, pointers, count, dout and dout_valid all hold.
REQ-008 SHALL have port flush, input, 1 bit: synchronous empty request.
REQ-009 SHALL have port level_cfg, input, CW bits: runtime full threshold.
REQ-010 SHALL have port push, input, 1 bit, and din, input, DATA_W bits: write request and data.
REQ-011 SHALL have port pop, input, 1 bit: read request.
REQ-012 SHALL have port dout, output, DATA_W bits, and dout_valid, output, 1 bit: read data and its qualifier.
REQ-013 SHALL have ports full, empty and almost_full, outputs, 1 bit each: status flags.
REQ-014 SHALL have port count, output, CW bits: current occupancy.
REQ-015 SHALL have ports overflow and underflow, outputs, 1 bit each: sticky error flags.
REQ-016 SHALL have port clear_err, input, 1 bit: clears the sticky error flags.

Function
REQ-017 SHALL compute the effective threshold lim = DEPTH when level_cfg is 0 or greater than DEPTH, and lim = level_cfg otherwise.
REQ-018 SHALL drive combinational flags: full = (count >= lim); empty = (count == 0); almost_full = (count >= lim-1).
REQ-019 SHALL qualify each request with enable and the pre-edge flags: push_acc = enable & push & !full & !flush; pop_acc = enable & pop & !empty & !flush.
REQ-020 SHALL, on push_acc, write din to mem[wr_ptr] and advance wr_ptr modulo DEPTH.
REQ-021 SHALL, on pop_acc, advance rd_ptr modulo DEPTH.
REQ-022 SHALL allow simultaneous push_acc and pop_acc; count changes by push_acc minus pop_acc and is unchanged when both occur.
REQ-023 SHALL, when full, reject push even if pop_acc is asserted in the same cycle.
REQ-024 SHALL, in FWFT=0 mode, register dout = mem[rd_ptr] on pop_acc with 1-cycle latency, pulse dout_valid for exactly one cycle after each pop_acc, and otherwise hold dout.
REQ-025 SHALL, in FWFT=1 mode, drive dout = mem[rd_ptr] combinationally and dout_valid = !empty; pop acknowledges the presented word.
REQ-026 SHALL, on enable & flush, set wr_ptr, rd_ptr and count to 0 and dout_valid to 0, leave dout unchanged, and give flush priority over push and pop.
REQ-027 SHALL let a level_cfg change take effect on flags combinationally, with no change to stored data; count may then exceed lim, and full stays asserted until count drops below lim.
REQ-028 SHALL set overflow on enable & push & full & !flush, and set underflow on enable & pop & empty & !flush.
REQ-029 SHALL clear overflow and underflow on clear_err; a set in the same cycle wins over clear_err.
REQ-030 SHALL update error flags and clear_err regardless of enable.

Reset
REQ-031 SHALL, while rst_n is low, force wr_ptr, rd_ptr, count, dout, dout_valid, overflow and underflow to 0; this gives empty=1, full=0 and almost_full=0 for lim>1.
REQ-032 SHALL leave storage contents unreset.
REQ-033 SHALL discard an operation in flight on reset assertion; the first accepted push after deassertion lands in entry 0.

Structure
REQ-034 SHALL place the default DATA_W and DEPTH, and an enum for the FWFT modes, in package acc_fifo_pkg.
REQ-035 SHALL put storage in sub-module acc_fifo_mem: a DEPTH x DATA_W array with one write port and one asynchronous read port, and no reset.
REQ-036 SHALL keep pointer, count, flag and error logic in acc_fifo.

Verification
REQ-037 SHALL cover the fill/drain scenario: DEPTH=16, level_cfg=0, pushing 0x00..0x0F -> full after the 16th push; 16 pops return 0x00..0x0F in order (FWFT=0: each one cycle after its pop); then empty=1.
REQ-038 SHALL cover the threshold scenario: level_cfg=4, 5 pushes -> almost_full at count=3, full at count=4, 5th push rejected, overflow=1, count=4.
REQ-039 SHALL cover the simultaneous scenario: count=8, push and pop held for 20 cycles -> count stays 8 and pointers wrap, with data order preserved.
REQ-040 SHALL cover the flush and enable scenario: count=6, flush with push and pop asserted -> count=0 next cycle and no write; enable=0 with push asserted -> no state change.
REQ-041 SHALL cover the error scenario: pop on empty -> underflow=1; clear_err together with a new pop on empty -> underflow stays 1; clear_err alone -> 0.
REQ-042 SHALL cover the reset scenario: rst_n asserted at count=5 mid-burst -> all outputs 0 immediately and empty=1; the next push is read back correctly.
